bus_reg_slave: RTL and testbench
================================

# bus_reg_slave

Memory-mapped register-bank responder on one slave port of the bus interconnect, downstream of the address decoder that drives its `sel_i`. It accepts single read/write requests, inserts a programmable number of wait states, commits byte-enabled writes to an internal bank of `NumRegs` words, and returns a one-cycle response pulse with read data or an error flag. It also exports the register contents to the peripheral logic it fronts.

## Interface
- `DWidth`, 32: address and data width; multiple of 8.
- `BaseAddr`, '0: first byte address of the bank; word aligned.
- `NumRegs`, 4: number of `DWidth`-bit registers; at least 1.
- `WaitCycles`, 1: wait states between accept and response; 0..15.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  asynchronous reset, active low.
- `sel_i`  in  1  slave select from the bus decoder.
- `req_i`  in  1  master request valid.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  DWidth  byte address.
- `wdata_i`  in  DWidth  write data.
- `be_i`  in  DWidth/8  byte enables; bit k covers `wdata_i[8k+7:8k]`.
- `ready_o`  out  1  request accepted this cycle if `sel_i & req_i` are also high.
- `rvalid_o`  out  1  response valid; single-cycle pulse.
- `rdata_o`  out  DWidth  read data; valid with `rvalid_o`.
- `err_o`  out  1  error response; valid with `rvalid_o`.
- `regs_o`  out  NumRegs*DWidth  register bank; reg i occupies bits `[i*DWidth +: DWidth]`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `ready_o`=1. On `sel_i & req_i`, capture `we_i`, `addr_i`, `wdata_i`, `be_i` and the decoded error. Go to WAIT with counter = `WaitCycles`-1, or to RESP when `WaitCycles`=0.
- A request without `sel_i` is ignored.
- WAIT: `ready_o`=0. Decrement the counter each cycle and go to RESP when it reaches 0. Input changes, including `sel_i` deasserting, are ignored.
- RESP: `rvalid_o`=1 for exactly one cycle, then return to IDLE. No backpressure; the master must take the response.
- Offset = captured addr − `BaseAddr`. Error if `addr < BaseAddr`, `offset[1:0]`≠0 (for `DWidth`=32; generally offset not a multiple of `DWidth`/8), or word index ≥ `NumRegs`.
- Read OK: `rdata_o` = register value at the RESP cycle, `err_o`=0.
- Write OK: in the RESP cycle, update the bytes whose `be_i` bit is set; other bytes are unchanged. The new value is visible on `regs_o` the next cycle. `rdata_o`=0. `be_i`=0 gives an OK response with no change.
- Any error: no register change, `rdata_o`=0, `err_o`=1.
- Outside RESP, `rdata_o` and `err_o` are 0.
- Reset values: state IDLE, `ready_o`=1, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, all registers 0.
- Reset asserted mid-transaction aborts it. No response is issued, and a pending write is not committed.

## Timing
- Accept edge T, the first rising edge with `sel_i & req_i & ready_o`. `rvalid_o` is high in cycle T+1+`WaitCycles`.
- `ready_o` is low from T+1 until the return to IDLE, so the next accept is no earlier than T+2+`WaitCycles`.
- Back-to-back throughput: one transfer per `WaitCycles`+2 cycles.
- `ready_o` is decoded from the state register only; no combinational path from inputs.
- `rvalid_o`, `rdata_o` and `err_o` are registered outputs.

## Structure
- Shared package `bus_pkg`:
  - state enum `bus_slv_state_e` {IDLE, WAIT, RESP}
  - `WaitCntWidth` = 4
  - constant `BusErrNone`/`BusErrAddr` response codes, shared with the interconnect default slave.
- One sub-module `bus_wait_timer`: loadable down-counter with a `done` flag, reused by other slaves.

## Test plan
Bench configuration: `BaseAddr`=32'h1000_0000, `NumRegs`=4, `WaitCycles`=2.
- Reset, then write 32'hDEADBEEF to 32'h1000_0004 with `be_i`=4'hF -> `rvalid_o` 3 cycles after accept with `err_o`=0; `regs_o` word 1 = 32'hDEADBEEF the next cycle.
- Write 32'h1122_3344 to 32'h1000_0004 with `be_i`=4'b0101 -> word 1 = 32'hDE22BE44. A subsequent read returns 32'hDE22BE44.
- Reads of 32'h1000_0010 (out of range), 32'h1000_0002 (unaligned) and 32'h0FFF_FFFC (below base) -> `err_o`=1, `rdata_o`=0, no register change.
- `req_i`=1 with `sel_i`=0 -> no accept and no `rvalid_o`. Drop `sel_i` during WAIT -> response still issued at T+3.
- Hold `sel_i & req_i` high continuously -> accepts every 4 cycles. `ready_o` is low for 3 cycles after each accept.
- Assert `rst_ni`=0 during WAIT of a write of 32'h5 to word 0 -> no `rvalid_o`, word 0 stays 0, `ready_o`=1 immediately.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions for slaves on the interconnect: slave FSM states,
// wait-counter width and response codes also used by the default slave.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_slv_state_e;

  localparam int unsigned WaitCntWidth = 4;

  localparam logic BusErrNone = 1'b0;
  localparam logic BusErrAddr = 1'b1;

endpackage

// File: rtl/bus_reg_slave_if.sv
// Request/response channel between the interconnect and one register-bank slave.
interface bus_reg_slave_if #(
  parameter int unsigned DWidth = 32
) ();

  logic                  sel_i;
  logic                  req_i;
  logic                  we_i;
  logic [DWidth-1:0]     addr_i;
  logic [DWidth-1:0]     wdata_i;
  logic [DWidth/8-1:0]   be_i;
  logic                  ready_o;
  logic                  rvalid_o;
  logic [DWidth-1:0]     rdata_o;
  logic                  err_o;

  modport slave (
    input  sel_i, req_i, we_i, addr_i, wdata_i, be_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output sel_i, req_i, we_i, addr_i, wdata_i, be_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
module bus_wait_timer
  import bus_pkg::*;
#(
  parameter int unsigned Width = WaitCntWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bus_reg_slave.sv
// Register-bank slave: accepts one request at a time, waits WaitCycles,
// then pulses a registered response and commits byte-enabled writes.
module bus_reg_slave
  import bus_pkg::*;
#(
  parameter int unsigned       DWidth     = 32,
  parameter logic [DWidth-1:0] BaseAddr   = '0,
  parameter int unsigned       NumRegs    = 4,
  parameter int unsigned       WaitCycles = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  bus_reg_slave_if.slave            bus,
  output logic [NumRegs*DWidth-1:0] regs_o
);

  localparam int unsigned BeW     = DWidth / 8;
  localparam int unsigned AddrLsb = $clog2(BeW);
  localparam int unsigned IdxW    = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam logic [DWidth-1:0] AlignMask = DWidth'(BeW - 1);
  localparam logic [WaitCntWidth-1:0] WaitLoad =
    (WaitCycles == 0) ? '0 : WaitCntWidth'(WaitCycles - 1);

  bus_slv_state_e state_q, state_d;

  logic              accept;
  logic              tmr_load, tmr_dec, tmr_done;
  logic [DWidth-1:0] offset, word_off;
  logic [IdxW-1:0]   live_idx;
  logic              live_err;

  logic              we_p0;
  logic [DWidth-1:0] wdata_p0;
  logic [BeW-1:0]    be_p0;
  logic [IdxW-1:0]   idx_p0;
  logic              err_p0;

  logic              cur_we, cur_err;
  logic [IdxW-1:0]   cur_idx;

  logic              rvalid_p1, err_p1;
  logic [DWidth-1:0] rdata_p1;

  logic [NumRegs-1:0][DWidth-1:0] regs_q;

  assign accept = bus.sel_i & bus.req_i & (state_q == IDLE);

  // Address decode of the live request
  always_comb begin
    offset   = bus.addr_i - BaseAddr;
    word_off = offset >> AddrLsb;
    live_idx = word_off[IdxW-1:0];
    live_err = (bus.addr_i < BaseAddr) ||
               ((offset & AlignMask) != '0) ||
               (word_off >= DWidth'(NumRegs));
  end

  // Stage p0: request capture at accept
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p0    <= bus.we_i;
      wdata_p0 <= bus.wdata_i;
      be_p0    <= bus.be_i;
      idx_p0   <= live_idx;
      err_p0   <= live_err ? BusErrAddr : BusErrNone;
    end
  end

  // With zero wait states the response is built straight from the live request.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we  = bus.we_i;
      cur_idx = live_idx;
      cur_err = live_err ? BusErrAddr : BusErrNone;
    end else begin
      cur_we  = we_p0;
      cur_idx = idx_p0;
      cur_err = err_p0;
    end
  end

  bus_wait_timer #(
    .Width (WaitCntWidth)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (WaitLoad),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (WaitCycles == 0) ? RESP : WAIT;
      WAIT: if (tmr_done) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = (state_q == IDLE);
    tmr_load    = accept;
    tmr_dec     = (state_q == WAIT);
  end

  // Stage p1: registered response, loaded on the edge entering RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_p1 <= 1'b0;
      err_p1    <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      rvalid_p1 <= (state_d == RESP);
      err_p1    <= (state_d == RESP) && (cur_err == BusErrAddr);
      rdata_p1  <= ((state_d == RESP) && !cur_we && (cur_err == BusErrNone))
                   ? regs_q[cur_idx] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else if ((state_q == RESP) && we_p0 && (err_p0 == BusErrNone)) begin
      for (int k = 0; k < BeW; k++) begin
        if (be_p0[k]) regs_q[idx_p0][8*k +: 8] <= wdata_p0[8*k +: 8];
      end
    end
  end

  assign bus.rvalid_o = rvalid_p1;
  assign bus.rdata_o  = rdata_p1;
  assign bus.err_o    = err_p1;
  assign regs_o       = regs_q;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Directed bench for bus_reg_slave with BaseAddr 0x1000_0000, 4 regs, 2 wait states.
module tb_bus_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] regs;
  logic [127:0] exp_regs;
  int           n_chk = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  bus_reg_slave_if #(.DWidth(32)) bus ();

  bus_reg_slave #(
    .DWidth     (32),
    .BaseAddr   (32'h1000_0000),
    .NumRegs    (4),
    .WaitCycles (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .regs_o (regs)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One transfer; latency counted in negedges after the accept edge.
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output int lat, output logic [31:0] rd,
                      output logic er, output logic [127:0] rg_after);
    lat = 0; rd = '0; er = 1'b0; rg_after = '0;
    @(negedge clk);
    bus.sel_i = 1'b1; bus.req_i = 1'b1; bus.we_i = we;
    bus.addr_i = a; bus.wdata_i = wd; bus.be_i = be;
    @(negedge clk);
    bus.sel_i = 1'b0; bus.req_i = 1'b0; bus.wdata_i = 32'hFFFF_FFFF;
    bus.addr_i = 32'h1000_0008; bus.be_i = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (lat != 0 && k == lat + 1) rg_after = regs;
      if (bus.rvalid_o && lat == 0) begin
        lat = k; rd = bus.rdata_o; er = bus.err_o;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat;
    logic [31:0]  rd;
    logic         er;
    logic [127:0] rg;
    int           nv;

    bus.sel_i = 0; bus.req_i = 0; bus.we_i = 0;
    bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
    exp_regs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_regs", regs, 0);
    rst_n = 1'b1;

    xfer(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, lat, rd, er, rg);
    exp_regs[32 +: 32] = 32'hDEAD_BEEF;
    chk("wr1_lat", lat, 3);
    chk("wr1_err", er, 0);
    chk("wr1_rdata", rd, 0);
    chk("wr1_regs", rg, exp_regs);

    xfer(1, 32'h1000_0004, 32'h1122_3344, 4'b0101, lat, rd, er, rg);
    exp_regs[32 +: 32] = 32'hDE22_BE44;
    chk("wr_be_regs", rg, exp_regs);

    xfer(0, 32'h1000_0004, 32'h0, 4'hF, lat, rd, er, rg);
    chk("rd1_lat", lat, 3);
    chk("rd1_data", rd, 32'hDE22_BE44);
    chk("rd1_err", er, 0);

    xfer(1, 32'h1000_000C, 32'hAABB_CCDD, 4'hF, lat, rd, er, rg);
    exp_regs[96 +: 32] = 32'hAABB_CCDD;
    chk("wr3_regs", rg, exp_regs);
    xfer(1, 32'h1000_0000, 32'h5A5A_5A5A, 4'b1000, lat, rd, er, rg);
    exp_regs[0 +: 32] = 32'h5A00_0000;
    chk("wr0_regs", rg, exp_regs);
    xfer(0, 32'h1000_000C, 32'h0, 4'hF, lat, rd, er, rg);
    chk("rd3_data", rd, 32'hAABB_CCDD);
    xfer(0, 32'h1000_0000, 32'h0, 4'hF, lat, rd, er, rg);
    chk("rd0_data", rd, 32'h5A00_0000);
    xfer(1, 32'h1000_000C, 32'h1234_5678, 4'h0, lat, rd, er, rg);
    chk("be0_err", er, 0);
    chk("be0_lat", lat, 3);
    chk("be0_regs", rg, exp_regs);

    xfer(0, 32'h1000_0010, 32'h0, 4'hF, lat, rd, er, rg);
    chk("oor_err", er, 1); chk("oor_rdata", rd, 0); chk("oor_lat", lat, 3);
    xfer(0, 32'h1000_0002, 32'h0, 4'hF, lat, rd, er, rg);
    chk("unal_err", er, 1); chk("unal_rdata", rd, 0);
    xfer(0, 32'h0FFF_FFFC, 32'h0, 4'hF, lat, rd, er, rg);
    chk("below_err", er, 1); chk("below_rdata", rd, 0);
    xfer(1, 32'h1000_0010, 32'hFFFF_FFFF, 4'hF, lat, rd, er, rg);
    chk("oor_wr_err", er, 1); chk("oor_wr_regs", rg, exp_regs);
    xfer(1, 32'h1000_0006, 32'hFFFF_FFFF, 4'hF, lat, rd, er, rg);
    chk("unal_wr_err", er, 1); chk("unal_wr_regs", rg, exp_regs);

    // Request without select
    @(negedge clk);
    bus.sel_i = 0; bus.req_i = 1; bus.we_i = 1; bus.addr_i = 32'h1000_0000;
    bus.wdata_i = 32'hFFFF_FFFF; bus.be_i = 4'hF;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rvalid_o) nv++;
      chk("nosel_ready", bus.ready_o, 1);
    end
    chk("nosel_rvalid", nv, 0);
    chk("nosel_regs", regs, exp_regs);
    bus.req_i = 0;

    // Select dropped during WAIT while req stays high
    @(negedge clk);
    bus.sel_i = 1; bus.req_i = 1; bus.we_i = 0; bus.addr_i = 32'h1000_0004;
    @(negedge clk);
    bus.sel_i = 0;
    chk("dsel_idle_rdata", bus.rdata_o, 0);
    chk("dsel_ready_low", bus.ready_o, 0);
    lat = 0; nv = 0; rd = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.rvalid_o) begin
        nv++;
        if (lat == 0) begin lat = k; rd = bus.rdata_o; end
      end
    end
    chk("dsel_lat", lat, 3);
    chk("dsel_count", nv, 1);
    chk("dsel_data", rd, 32'hDE22_BE44);
    bus.req_i = 0;

    // Continuous request: accept every 4 cycles
    @(negedge clk);
    bus.sel_i = 1; bus.req_i = 1; bus.we_i = 0; bus.addr_i = 32'h1000_000C;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("hold_ready", bus.ready_o, (n % 4) == 0);
      chk("hold_rvalid", bus.rvalid_o, (n % 4) == 3);
    end
    bus.sel_i = 0; bus.req_i = 0;

    // Reset during WAIT of a write to word 0
    @(negedge clk);
    bus.sel_i = 1; bus.req_i = 1; bus.we_i = 1; bus.addr_i = 32'h1000_0000;
    bus.wdata_i = 32'h5; bus.be_i = 4'hF;
    @(negedge clk);
    bus.sel_i = 0; bus.req_i = 0;
    chk("abort_in_wait", bus.ready_o, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", bus.ready_o, 1);
    chk("abort_rvalid_now", bus.rvalid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rvalid_o) nv++;
    end
    chk("abort_rvalid", nv, 0);
    chk("abort_word0", regs[31:0], 0);
    chk("abort_ready_after", bus.ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
